// File: rtl/q_pkg.sv
// Shared types, defaults and helpers for the Q-flop async-to-clocked boundary blocks.
package q_pkg;

    localparam int unsigned Q_WIDTH       = 8;
    localparam int unsigned Q_DEPTH       = 4;
    localparam int unsigned Q_SYNC_STAGES = 2;

    typedef enum logic {
        Q_IDLE  = 1'b0,
        Q_ACKED = 1'b1
    } q_state_e;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int unsigned q_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/q_sync.sv
// Multi-flop level synchroniser for an asynchronous input, cleared by rst_l.
module q_sync
    import q_pkg::*;
#(
    parameter int unsigned STAGES = Q_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_l,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/q_sync_fifo.sv
// 4-phase req/ack capture of bundled data into a small FIFO, drained by a valid/ready consumer.
module q_sync_fifo
    import q_pkg::*;
#(
    parameter int unsigned WIDTH       = Q_WIDTH,
    parameter int unsigned DEPTH       = Q_DEPTH,
    parameter int unsigned SYNC_STAGES = Q_SYNC_STAGES
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     a_req,
    input  logic [WIDTH-1:0]         a_data,
    output logic                     a_ack,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = q_ptr_w(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic             req_s;
    q_state_e         state_q;
    q_state_e         state_d;
    logic             push;
    logic             pop;
    logic             can_push;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_next;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] mem [DEPTH];

    q_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .rst_l (rst_l),
        .d     (a_req),
        .q     (req_s)
    );

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign can_push  = (count_q < FULL_CNT) || pop;
    assign rd_next   = rd_ptr + PW'(1);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= Q_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            Q_IDLE: begin
                if (req_s && can_push) begin
                    push    = 1'b1;
                    state_d = Q_ACKED;
                end
            end
            Q_ACKED: begin
                if (!req_s) begin
                    state_d = Q_IDLE;
                end
            end
            default: state_d = Q_IDLE;
        endcase
    end

    // Ack is the registered FSM state, so it can never glitch.
    assign a_ack = (state_q == Q_ACKED);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= a_data;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + ONE_CNT;
                2'b01:   count_q <= count_q - ONE_CNT;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head is kept in its own register so out_data has a defined reset value
    // while the storage array stays unreset; it mirrors mem[rd_ptr] and holds
    // the last popped word once the FIFO drains.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            head_q <= '0;
        end else if (push && ((count_q == '0) || (pop && (count_q == ONE_CNT)))) begin
            head_q <= a_data;
        end else if (pop && (count_q > ONE_CNT)) begin
            head_q <= mem[rd_next];
        end
    end

    assign out_data = head_q;
    assign count    = count_q;

endmodule

// File: doc/q_sync_fifo.md
# q_sync_fifo

Parametrised successor to the single-bit Q-flop stage. It accepts a WIDTH-bit bundled-data word from an asynchronous (self-timed) producer using a 4-phase req/ack handshake. It resolves the request through a SYNC_STAGES-deep synchroniser, buffers words in a DEPTH-entry FIFO, and presents them to the clocked pipeline on a valid/ready interface. It sits at every async-to-clocked boundary of the Q-flop pipeline.

## Interface
- WIDTH, 8: data bits per word (≥1)
- DEPTH, 4: FIFO entries (power of two, ≥2)
- SYNC_STAGES, 2: flops in the req synchroniser (≥2)

- clk  in  1  rising-edge clock
- rst_l  in  1  asynchronous, active-low reset
- a_req  in  1  async 4-phase request; level, unrelated to clk
- a_data  in  WIDTH  bundled data; stable from a_req rise until a_ack rise
- a_ack  out  1  4-phase acknowledge; registered, glitch-free
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head this cycle
- out_data  out  WIDTH  FIFO head word
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Reset (rst_l=0, async):
  - a_ack=0, out_valid=0, out_data=0, count=0.
  - Synchroniser flops cleared; FSM in IDLE.
- Synchroniser: a_req passes through SYNC_STAGES flops, producing req_s. Only req_s is used in logic. a_req is never used combinationally.
- Handshake FSM, two states:
  - IDLE (a_ack=0):
    - If req_s=1 and can_push: write a_data into the FIFO, set a_ack=1 at the same edge, go to ACKED.
    - If req_s=1 and FIFO full without a pop: stay in IDLE and hold a_ack=0 (backpressure to producer).
  - ACKED (a_ack=1): when req_s=0, clear a_ack=0 and go to IDLE.
  - A req_s that stays high in IDLE after a completed cycle cannot occur under legal 4-phase operation.
- can_push = (count<DEPTH) or (out_valid and out_ready), so a push is permitted into a full FIFO when a pop happens in the same cycle.
- Pop: out_valid and out_ready at a clock edge removes the head.
- Count rules:
  - Push only: +1. Pop only: −1. Push and pop together: count unchanged.
  - count never exceeds DEPTH and never underflows.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from count, not from pointer compare.
- out_data equals the memory at the read pointer. When empty, it holds the last popped value; consumers must ignore it when out_valid=0.
- Reset during a handshake:
  - a_ack drops immediately and buffered words are discarded.
  - If a_req is still high after reset releases, it is treated as a new request and the word is captured again.
  - Producers must treat reset as an abort.

## Timing
- a_req rise to a_ack rise: SYNC_STAGES+1 clk edges when not full (first edge samples a_req). This can vary by +1 due to metastability resolution.
- a_req fall to a_ack fall: SYNC_STAGES+1 edges.
- Minimum full 4-phase cycle: 2·(SYNC_STAGES+1) edges, plus producer delays.
- Push to out_valid: a word written at edge N is visible on out_valid/out_data after edge N, the same edge at which a_ack rises. There is no bypass path.
- Pop to next head: next word (or out_valid=0) is visible after the popping edge.
- Simultaneous push and pop on an empty FIFO cannot occur, because out_valid=0.

## Structure
- Shared package q_pkg holds:
  - the FSM state enum (Q_IDLE, Q_ACKED);
  - a ptr-width helper function;
  - default parameter constants.
- Sub-module q_sync: a SYNC_STAGES-deep, rst_l-cleared synchroniser, instantiated once for a_req. It is reusable for other async levels.
- The FIFO storage is inline: a register array with no reset on data, and reset on pointers and count only.

## Test plan
- Single transfer: DEPTH=4, SYNC_STAGES=2, a_data=0xA5, raise a_req.
  - a_ack=1 exactly 3 edges later; out_valid=1 with out_data=0xA5 on the same edge.
  - Drop a_req → a_ack=0 after 3 edges.
- Fill to full with out_ready=0 and four words 0x01..0x04:
  - count=4.
  - A fifth a_req gets no a_ack.
  - Pulse out_ready once → the fifth word is accepted (a_ack rises after that edge) and count stays 4.
- Ordering and wrap: stream 10 words 0x10..0x19 with out_ready=1 throughout → outputs appear in order, count≤DEPTH, pointers wrap without loss.
- Simultaneous push and pop at count=2 → count remains 2 and the head advances correctly.
- Reset mid-handshake:
  - Assert rst_l=0 while a_ack=1 → a_ack, out_valid and count are 0 immediately (asynchronous).
  - Release rst_l with a_req high → the word is re-captured and a_ack rises 3 edges later.
- Parameter sweep: WIDTH=1/32, DEPTH=2/16, SYNC_STAGES=3 → the ack latency becomes SYNC_STAGES+1 and all of the above scenarios pass.
